// File: rtl/line_mem_responder_if.sv
// Line-memory request/response bundle between a requester (master)
// and the line_mem_responder (slave).
interface line_mem_responder_if #(
    parameter int s_line = 256
) ();
    logic              downstream_read;
    logic              downstream_write;
    logic [31:0]       downstream_address;
    logic [s_line-1:0] downstream_wdata;
    logic [s_line-1:0] downstream_rdata;
    logic              downstream_resp;
    logic              proto_err;

    modport master (
        output downstream_read,
        output downstream_write,
        output downstream_address,
        output downstream_wdata,
        input  downstream_rdata,
        input  downstream_resp,
        input  proto_err
    );

    modport slave (
        input  downstream_read,
        input  downstream_write,
        input  downstream_address,
        input  downstream_wdata,
        output downstream_rdata,
        output downstream_resp,
        output proto_err
    );
endinterface

// File: rtl/line_mem_responder.sv
// Fixed-latency line memory: samples one read/write request in IDLE,
// waits LATENCY cycles, then strobes downstream_resp for one cycle.
module line_mem_responder #(
    parameter int s_offset = 5,
    parameter int s_line   = 8 * 2**s_offset,
    parameter int s_depth  = 4,
    parameter int LATENCY  = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    line_mem_responder_if.slave bus
);

    localparam int         n_lines     = 2**s_depth;
    localparam logic [3:0] lat_load    = 4'(LATENCY - 1);
    localparam bit         direct_resp = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_next_s;
    logic               sample_s;
    logic               op_write_r;
    logic               op_write_next_s;
    logic [s_depth-1:0] idx_r;
    logic [s_depth-1:0] idx_next_s;
    logic [s_depth-1:0] req_idx_s;
    logic [s_line-1:0]  wdata_r;
    logic [s_line-1:0]  rdata_r;
    logic               resp_r;
    logic               proto_err_r;
    logic [s_line-1:0]  mem_r [n_lines];
    logic               unused_addr_s;

    // Offset and upper address bits deliberately do not take part in decode.
    assign req_idx_s     = bus.downstream_address[s_offset+s_depth-1:s_offset];
    assign unused_addr_s = ^{bus.downstream_address[31:s_offset+s_depth],
                             bus.downstream_address[s_offset-1:0]};

    // Next-state, counter and request-sampling decode.
    always_comb begin
        state_next_s    = state_r;
        cnt_next_s      = cnt_r;
        sample_s        = 1'b0;
        op_write_next_s = op_write_r;
        idx_next_s      = idx_r;
        case (state_r)
            IDLE: begin
                if (bus.downstream_read || bus.downstream_write) begin
                    sample_s        = 1'b1;
                    cnt_next_s      = lat_load;
                    // Simultaneous read and write resolves to a write.
                    op_write_next_s = bus.downstream_write;
                    idx_next_s      = req_idx_s;
                    state_next_s    = direct_resp ? RESP : WAIT;
                end else begin
                    state_next_s    = IDLE;
                end
            end
            WAIT: begin
                cnt_next_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // FSM state and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Transaction context captured at the sampling edge; held through WAIT/RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_write_r <= 1'b0;
            idx_r      <= '0;
            wdata_r    <= '0;
        end else if (sample_s) begin
            op_write_r <= op_write_next_s;
            idx_r      <= idx_next_s;
            wdata_r    <= bus.downstream_wdata;
        end else begin
            op_write_r <= op_write_r;
            idx_r      <= idx_r;
            wdata_r    <= wdata_r;
        end
    end

    // Line storage; a write commits on the edge that ends its RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < n_lines; i++) begin
                mem_r[i] <= '0;
            end
        end else if ((state_r == RESP) && op_write_r) begin
            mem_r[idx_r] <= wdata_r;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Registered response strobe and read data, loaded on entry to RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_r  <= 1'b0;
            rdata_r <= '0;
        end else begin
            resp_r <= (state_next_s == RESP);
            if ((state_next_s == RESP) && !op_write_next_s) begin
                rdata_r <= mem_r[idx_next_s];
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_r <= 1'b0;
        end else if (sample_s && bus.downstream_read && bus.downstream_write) begin
            proto_err_r <= 1'b1;
        end else begin
            proto_err_r <= proto_err_r;
        end
    end

    assign bus.downstream_resp  = resp_r;
    assign bus.downstream_rdata = rdata_r;
    assign bus.proto_err        = proto_err_r;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed self-checking bench for line_mem_responder: a LATENCY=4 instance
// and a LATENCY=1 instance sharing clock and reset.
module tb_line_mem_responder;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    localparam logic [255:0] pat_a5 = {32{8'hA5}};
    localparam logic [255:0] pat_c3 = {32{8'hC3}};
    localparam logic [255:0] pat_ff = {256{1'b1}};
    localparam logic [255:0] zero   = 256'd0;

    line_mem_responder_if #(.s_line(256)) bus0 ();
    line_mem_responder_if #(.s_line(256)) bus1 ();

    line_mem_responder #(.LATENCY(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    line_mem_responder #(.LATENCY(1)) u_dut_l1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Request held until resp is seen; resp must appear only in cycle 4.
    task automatic txn(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [255:0] wd, input bit chk_rd, input logic [255:0] exp_rd);
        bus0.downstream_read    = rd;
        bus0.downstream_write   = wr;
        bus0.downstream_address = addr;
        bus0.downstream_wdata   = wd;
        @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            #1;
            check_value({tag, "_resp"}, {255'd0, bus0.downstream_resp}, {255'd0, (i == 4)});
            if (i == 4) begin
                if (chk_rd) check_value({tag, "_rdata"}, bus0.downstream_rdata, exp_rd);
                bus0.downstream_read  = 1'b0;
                bus0.downstream_write = 1'b0;
            end else begin
                @(posedge clk);
            end
        end
        @(posedge clk);
        #1;
        check_value({tag, "_idle"}, {255'd0, bus0.downstream_resp}, zero);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus0.downstream_read    = 1'b0;
        bus0.downstream_write   = 1'b0;
        bus0.downstream_address = 32'd0;
        bus0.downstream_wdata   = zero;
        bus1.downstream_read    = 1'b0;
        bus1.downstream_write   = 1'b0;
        bus1.downstream_address = 32'd0;
        bus1.downstream_wdata   = zero;

        repeat (2) @(posedge clk);
        #1;
        check_value("rst_resp",  {255'd0, bus0.downstream_resp}, zero);
        check_value("rst_rdata", bus0.downstream_rdata, zero);
        check_value("rst_perr",  {255'd0, bus0.proto_err}, zero);
        check_value("rst_l1_rdata", bus1.downstream_rdata, zero);

        @(negedge clk);
        rst_n = 1'b1;

        txn("wr40",  1'b0, 1'b1, 32'h0000_0040, pat_a5, 1'b0, zero);
        check_value("wr40_perr", {255'd0, bus0.proto_err}, zero);
        txn("rd40",  1'b1, 1'b0, 32'h0000_0040, zero, 1'b1, pat_a5);
        txn("rd5f",  1'b1, 1'b0, 32'h0000_005F, zero, 1'b1, pat_a5);
        txn("rd240", 1'b1, 1'b0, 32'h0000_0240, zero, 1'b1, pat_a5);
        txn("rd60",  1'b1, 1'b0, 32'h0000_0060, zero, 1'b1, zero);

        // Read 0x40, then drop read and move address/wdata during WAIT.
        bus0.downstream_read    = 1'b1;
        bus0.downstream_address = 32'h0000_0040;
        @(posedge clk);
        #1;
        check_value("drop_resp1", {255'd0, bus0.downstream_resp}, zero);
        bus0.downstream_read    = 1'b0;
        bus0.downstream_address = 32'h0000_0060;
        bus0.downstream_wdata   = pat_ff;
        for (int i = 2; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check_value("drop_resp", {255'd0, bus0.downstream_resp}, {255'd0, (i == 4)});
        end
        check_value("drop_rdata", bus0.downstream_rdata, pat_a5);
        @(posedge clk);
        #1;
        check_value("drop_idle", {255'd0, bus0.downstream_resp}, zero);

        txn("wr60",  1'b0, 1'b1, 32'h0000_0060, 256'h1234, 1'b1, pat_a5);
        txn("rd60b", 1'b1, 1'b0, 32'h0000_0060, zero, 1'b1, 256'h1234);
        txn("rw20",  1'b1, 1'b1, 32'h0000_0020, 256'h1, 1'b1, 256'h1234);
        check_value("rw20_perr", {255'd0, bus0.proto_err}, {255'd0, 1'b1});
        txn("rd20",  1'b1, 1'b0, 32'h0000_0020, zero, 1'b1, 256'h1);
        check_value("rd20_perr", {255'd0, bus0.proto_err}, {255'd0, 1'b1});

        // Write 0x80 interrupted by reset in the second WAIT cycle.
        bus0.downstream_write   = 1'b1;
        bus0.downstream_address = 32'h0000_0080;
        bus0.downstream_wdata   = pat_ff;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus0.downstream_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_value("rst_mid_resp", {255'd0, bus0.downstream_resp}, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_value("rst_post_resp", {255'd0, bus0.downstream_resp}, zero);
        end
        check_value("rst_post_perr", {255'd0, bus0.proto_err}, zero);
        txn("rd80", 1'b1, 1'b0, 32'h0000_0080, zero, 1'b1, zero);
        txn("rd40z", 1'b1, 1'b0, 32'h0000_0040, zero, 1'b1, zero);

        // LATENCY=1: write then immediate read; request switched during RESP.
        bus1.downstream_write   = 1'b1;
        bus1.downstream_address = 32'h0000_0040;
        bus1.downstream_wdata   = pat_c3;
        @(posedge clk);
        #1;
        check_value("l1_c1_resp", {255'd0, bus1.downstream_resp}, {255'd0, 1'b1});
        bus1.downstream_write = 1'b0;
        bus1.downstream_read  = 1'b1;
        @(posedge clk);
        #1;
        check_value("l1_c2_resp", {255'd0, bus1.downstream_resp}, zero);
        @(posedge clk);
        #1;
        check_value("l1_c3_resp",  {255'd0, bus1.downstream_resp}, {255'd0, 1'b1});
        check_value("l1_c3_rdata", bus1.downstream_rdata, pat_c3);
        @(posedge clk);
        #1;
        check_value("l1_c4_resp", {255'd0, bus1.downstream_resp}, zero);
        @(posedge clk);
        #1;
        check_value("l1_c5_resp", {255'd0, bus1.downstream_resp}, {255'd0, 1'b1});
        bus1.downstream_read = 1'b0;
        @(posedge clk);
        #1;
        check_value("l1_c6_resp", {255'd0, bus1.downstream_resp}, zero);
        check_value("l1_perr",    {255'd0, bus1.proto_err}, zero);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
